dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Sequencing controller between the instruction queue and the combinational decode stage of the out-of-order core. It pops 64-bit {pc, inst} packets from the queue into a single holding register that drives decode, classifies each instruction by opcode, and issues it only when the ROB and the required back-end structure (reservation station or load/store queue) can all accept it in the same cycle. It also serializes CSR instructions behind an empty ROB, handles pipeline flush, and keeps dispatch/stall performance counters.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  mispredict/redirect flush; highest priority
- iq_valid  in  1  instruction queue has a packet
- iq_packet  in  64  {pc[63:32], inst[31:0]}
- iq_ready  out  1  pop strobe to instruction queue
- dec_valid  out  1  holding register valid (drives decode valid_inst)
- dec_packet  out  64  holding register contents (drives decode queue_packet)
- rob_ready  in  1  ROB not full
- rob_empty  in  1  ROB holds no instructions
- rs_ready  in  1  reservation station has a free entry
- lsq_ready  in  1  load/store queue has a free entry
- rob_alloc  out  1  allocate ROB entry this cycle
- rs_alloc  out  1  write decoded instruction into reservation station
- lsq_alloc  out  1  write decoded instruction into load/store queue
- dispatch_cnt  out  CNT_W  instructions dispatched since reset
- stall_cnt  out  CNT_W  cycles with a held instruction not dispatched

## Operation
- Class from dec_packet[6:0]: 0000011/0100011 -> MEM; 1110011 -> CSR; all other opcodes -> ALU (includes lui, auipc, jal, jalr, branch, imm, reg, unknown).
- States: EMPTY (register invalid), HOLD (register valid), FLUSH (one-cycle recovery).
- can_go (HOLD only): rob_ready && (ALU: rs_ready; MEM: lsq_ready; CSR: rob_empty).
- dispatch = HOLD && can_go && !flush. On dispatch: rob_alloc=1; rs_alloc=1 for ALU; lsq_alloc=1 for MEM; CSR asserts rob_alloc only. Exactly these strobes, all combinational, all same cycle; otherwise all 0.
- iq_ready = !flush && state!=FLUSH && (state==EMPTY || dispatch). Pop occurs when iq_valid && iq_ready; packet captured at clock edge.
- Transitions: EMPTY -> HOLD on pop. HOLD -> HOLD on dispatch with pop (back-to-back), or no dispatch. HOLD -> EMPTY on dispatch without pop. Any state -> FLUSH on flush. FLUSH -> EMPTY unconditionally (iq_ready=0 in FLUSH so queue can clear).
- flush: register invalidated at edge, no allocation strobes, no pop, counters not incremented that cycle.
- dispatch_cnt += 1 per dispatch; stall_cnt += 1 per HOLD cycle with !dispatch && !flush. Both wrap modulo 2^CNT_W.
- dec_valid = (state==HOLD). dec_packet holds its value while not popping; contents don't-care when dec_valid=0.

## Timing
- Reset (rst=0 at edge): state EMPTY, dec_valid=0, dec_packet=0, both counters 0; hence iq_ready=1 (if not flush), all alloc strobes 0.
- Latency: packet popped at edge N is on dec_packet with dec_valid=1 in cycle N+1; earliest dispatch in cycle N+1.
- Sustained throughput 1 instruction/cycle when all ready inputs stay high.
- Ready inputs sampled combinationally in the dispatch cycle; no registered backpressure.
- flush concurrent with reset: reset wins. flush concurrent with can_go: no dispatch.
- CSR with rob_empty=0: held indefinitely, stall_cnt counts each cycle.
- Counter at 2^CNT_W-1 wraps to 0 on next increment.

## Test plan
- Reset then iq_valid=1 streaming 4 ALU packets, all readies=1 -> dec_valid from cycle 1, rob_alloc=rs_alloc=1 cycles 1-4, dispatch_cnt=4, stall_cnt=0.
- Load packet (opcode 0000011) with lsq_ready=0 for 3 cycles then 1 -> no allocs for 3 cycles, stall_cnt=3, then rob_alloc=lsq_alloc=1, rs_alloc=0, iq_ready=1 that cycle.
- rob_ready=0 with ALU held and rs_ready=1 -> no strobes, iq_ready=0, dec_packet stable.
- CSR packet with rob_empty=0 for 5 cycles -> stalls 5 cycles, then on rob_empty=1 only rob_alloc pulses; dispatch_cnt+1.
- Flush while HOLD with can_go=1 -> no strobes, next cycle dec_valid=0 and iq_ready=0 (FLUSH), following cycle iq_ready=1.
- CNT_W=4, 16 dispatches -> dispatch_cnt wraps to 0; rst=0 mid-stall -> all counters and dec_valid 0 next cycle.

Source files
------------

// File: rtl/dispatch_if.sv
// Bundle between the dispatch controller, instruction queue, decode stage and back-end
// structures. master = dispatch controller, slave = surrounding pipeline.
interface dispatch_if;
    logic        iq_valid;
    logic [63:0] iq_packet;
    logic        iq_ready;
    logic        dec_valid;
    logic [63:0] dec_packet;
    logic        rob_ready;
    logic        rob_empty;
    logic        rs_ready;
    logic        lsq_ready;
    logic        rob_alloc;
    logic        rs_alloc;
    logic        lsq_alloc;

    modport master (
        input  iq_valid, iq_packet, rob_ready, rob_empty, rs_ready, lsq_ready,
        output iq_ready, dec_valid, dec_packet, rob_alloc, rs_alloc, lsq_alloc
    );

    modport slave (
        output iq_valid, iq_packet, rob_ready, rob_empty, rs_ready, lsq_ready,
        input  iq_ready, dec_valid, dec_packet, rob_alloc, rs_alloc, lsq_alloc
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Holds one {pc, inst} packet in front of decode and issues it when the ROB and the
// matching back-end structure can both accept; serializes CSRs behind an empty ROB.
module dispatch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    dispatch_if.master       bus,
    output logic [CNT_W-1:0] dispatch_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MEM = 2'd1,
        CLS_CSR = 2'd2
    } cls_t;

    state_t      state_reg, state_next;
    logic [63:0] packet_reg;
    cls_t        cls;
    logic        can_go;
    logic        dispatch;
    logic        pop;
    logic        iq_ready_int;
    logic [1:0]  cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    always_comb begin
        cls = CLS_ALU;
        unique case (packet_reg[6:0])
            7'b0000011, 7'b0100011: cls = CLS_MEM;
            7'b1110011:             cls = CLS_CSR;
            default:                cls = CLS_ALU;
        endcase
    end

    // CSRs wait for the ROB to drain so their side effects stay in program order.
    always_comb begin
        can_go = 1'b0;
        if (state_reg == ST_HOLD && bus.rob_ready) begin
            unique case (cls)
                CLS_MEM: can_go = bus.lsq_ready;
                CLS_CSR: can_go = bus.rob_empty;
                default: can_go = bus.rs_ready;
            endcase
        end
    end

    assign dispatch     = (state_reg == ST_HOLD) && can_go && !flush;
    assign iq_ready_int = !flush && (state_reg != ST_FLUSH) &&
                          ((state_reg == ST_EMPTY) || dispatch);
    assign pop          = bus.iq_valid && iq_ready_int;

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_FLUSH;
        end else begin
            unique case (state_reg)
                ST_EMPTY: if (pop) state_next = ST_HOLD;
                ST_HOLD:  if (dispatch && !pop) state_next = ST_EMPTY;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= ST_EMPTY;
            packet_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) packet_reg <= bus.iq_packet;
        end
    end

    assign cnt_inc[0] = dispatch;
    assign cnt_inc[1] = (state_reg == ST_HOLD) && !dispatch && !flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst)
                    cnt_reg <= '0;
                else if (cnt_inc[gi])
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign dispatch_cnt   = cnt_val[0];
    assign stall_cnt      = cnt_val[1];

    assign bus.iq_ready   = iq_ready_int;
    assign bus.dec_valid  = (state_reg == ST_HOLD);
    assign bus.dec_packet = packet_reg;
    assign bus.rob_alloc  = dispatch;
    assign bus.rs_alloc   = dispatch && (cls == CLS_ALU);
    assign bus.lsq_alloc  = dispatch && (cls == CLS_MEM);

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl with a 4-bit counter build so wrap-around is reachable.
module tb_dispatch_ctrl;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [CNT_W-1:0] dispatch_cnt, stall_cnt;
    int total = 0;
    int bad   = 0;

    dispatch_if bus ();

    dispatch_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .dispatch_cnt (dispatch_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [63:0] mk(input logic [31:0] pc, input logic [6:0] op);
        return {pc, 25'h0ABCDE, op};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic r, input logic s, input logic l);
        chk({tag, ".rob_alloc"}, {63'd0, bus.rob_alloc}, {63'd0, r});
        chk({tag, ".rs_alloc"},  {63'd0, bus.rs_alloc},  {63'd0, s});
        chk({tag, ".lsq_alloc"}, {63'd0, bus.lsq_alloc}, {63'd0, l});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.iq_valid = 1'b0;
        cyc();
        rst = 1'b1;
        flush = 1'b0;
        bus.rob_ready = 1'b1;
        bus.rob_empty = 1'b1;
        bus.rs_ready  = 1'b1;
        bus.lsq_ready = 1'b1;
        #1;
    endtask

    logic [63:0] alu_pk [4];
    logic [63:0] pk;

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.iq_valid = 1'b0;
        bus.iq_packet = '0;
        bus.rob_ready = 1'b0;
        bus.rob_empty = 1'b0;
        bus.rs_ready = 1'b0;
        bus.lsq_ready = 1'b0;
        #1;

        // reset state
        do_reset();
        chk("rst.dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        chk("rst.dec_packet", bus.dec_packet, 64'd0);
        chk("rst.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd0);
        chk("rst.stall_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("rst.iq_ready", {63'd0, bus.iq_ready}, 64'd1);
        strobes("rst", 1'b0, 1'b0, 1'b0);

        // stream of four ALU-class packets (reg, imm, branch, unknown opcode)
        alu_pk[0] = mk(32'h1000, 7'b0110011);
        alu_pk[1] = mk(32'h1004, 7'b0010011);
        alu_pk[2] = mk(32'h1008, 7'b1100011);
        alu_pk[3] = mk(32'h100C, 7'b1111111);
        for (int i = 0; i <= 4; i++) begin
            bus.iq_valid  = (i < 4);
            bus.iq_packet = (i < 4) ? alu_pk[i] : 64'd0;
            #1;
            if (i >= 1) begin
                chk($sformatf("alu%0d.dec_packet", i), bus.dec_packet, alu_pk[i-1]);
                chk($sformatf("alu%0d.dec_valid", i), {63'd0, bus.dec_valid}, 64'd1);
                strobes($sformatf("alu%0d", i), 1'b1, 1'b1, 1'b0);
            end
            chk($sformatf("alu%0d.iq_ready", i), {63'd0, bus.iq_ready}, 64'd1);
            cyc();
        end
        bus.iq_valid = 1'b0;
        #1;
        chk("alu.drained", {63'd0, bus.dec_valid}, 64'd0);
        chk("alu.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd4);
        chk("alu.stall_cnt", {60'd0, stall_cnt}, 64'd0);

        // load waiting on LSQ
        do_reset();
        bus.lsq_ready = 1'b0;
        pk = mk(32'h2000, 7'b0000011);
        bus.iq_valid = 1'b1;
        bus.iq_packet = pk;
        cyc();
        bus.iq_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            strobes($sformatf("ld_stall%0d", i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("ld_stall%0d.iq_ready", i), {63'd0, bus.iq_ready}, 64'd0);
            cyc();
        end
        chk("ld.stall_cnt", {60'd0, stall_cnt}, 64'd3);
        bus.lsq_ready = 1'b1;
        #1;
        strobes("ld_go", 1'b1, 1'b0, 1'b1);
        chk("ld_go.iq_ready", {63'd0, bus.iq_ready}, 64'd1);
        cyc();
        chk("ld.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd1);
        chk("ld.stall_cnt_after", {60'd0, stall_cnt}, 64'd3);
        chk("ld.dec_valid", {63'd0, bus.dec_valid}, 64'd0);

        // store routes to LSQ
        pk = mk(32'h2100, 7'b0100011);
        bus.iq_valid = 1'b1;
        bus.iq_packet = pk;
        cyc();
        bus.iq_valid = 1'b0;
        #1;
        strobes("st", 1'b1, 1'b0, 1'b1);
        cyc();

        // ROB full blocks an otherwise-ready ALU op
        do_reset();
        pk = mk(32'h3000, 7'b0110111);
        bus.iq_valid = 1'b1;
        bus.iq_packet = pk;
        cyc();
        bus.rob_ready = 1'b0;
        bus.iq_packet = mk(32'h3004, 7'b0010111);
        for (int i = 0; i < 2; i++) begin
            #1;
            strobes($sformatf("robfull%0d", i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("robfull%0d.iq_ready", i), {63'd0, bus.iq_ready}, 64'd0);
            chk($sformatf("robfull%0d.dec_packet", i), bus.dec_packet, pk);
            cyc();
        end
        bus.rob_ready = 1'b1;
        #1;
        strobes("robfree", 1'b1, 1'b1, 1'b0);
        cyc();
        chk("robfree.next_packet", bus.dec_packet, mk(32'h3004, 7'b0010111));
        bus.iq_valid = 1'b0;
        cyc();
        chk("robfree.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd2);
        chk("robfree.stall_cnt", {60'd0, stall_cnt}, 64'd2);

        // CSR serialized behind a non-empty ROB
        do_reset();
        bus.rob_empty = 1'b0;
        bus.iq_valid = 1'b1;
        bus.iq_packet = mk(32'h4000, 7'b1110011);
        cyc();
        bus.iq_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            strobes($sformatf("csr_wait%0d", i), 1'b0, 1'b0, 1'b0);
            cyc();
        end
        chk("csr.stall_cnt", {60'd0, stall_cnt}, 64'd5);
        bus.rob_empty = 1'b1;
        #1;
        strobes("csr_go", 1'b1, 1'b0, 1'b0);
        cyc();
        chk("csr.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd1);

        // flush beats a ready dispatch, then one recovery cycle
        do_reset();
        bus.iq_valid = 1'b1;
        bus.iq_packet = mk(32'h5000, 7'b0110011);
        cyc();
        flush = 1'b1;
        #1;
        strobes("flush", 1'b0, 1'b0, 1'b0);
        chk("flush.iq_ready", {63'd0, bus.iq_ready}, 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_rec.dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        chk("fl_rec.iq_ready", {63'd0, bus.iq_ready}, 64'd0);
        strobes("fl_rec", 1'b0, 1'b0, 1'b0);
        chk("fl_rec.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd0);
        chk("fl_rec.stall_cnt", {60'd0, stall_cnt}, 64'd0);
        cyc();
        chk("fl_after.iq_ready", {63'd0, bus.iq_ready}, 64'd1);
        chk("fl_after.dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        bus.iq_valid = 1'b0;

        // 16 dispatches wrap the 4-bit counter
        do_reset();
        bus.iq_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.iq_packet = mk(32'h6000 + 32'(4 * i), 7'b0010011);
            cyc();
        end
        bus.iq_valid = 1'b0;
        #1;
        chk("wrap.pre_cnt", {60'd0, dispatch_cnt}, 64'd15);
        cyc();
        chk("wrap.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd0);

        // reset mid-stall, with flush asserted alongside (reset wins)
        bus.rs_ready = 1'b0;
        bus.iq_valid = 1'b1;
        bus.iq_packet = mk(32'h7000, 7'b0110011);
        cyc();
        bus.iq_valid = 1'b0;
        cyc();
        cyc();
        chk("midstall.stall_cnt", {60'd0, stall_cnt}, 64'd2);
        rst = 1'b0;
        flush = 1'b1;
        cyc();
        rst = 1'b1;
        flush = 1'b0;
        #1;
        chk("rst2.dec_valid", {63'd0, bus.dec_valid}, 64'd0);
        chk("rst2.stall_cnt", {60'd0, stall_cnt}, 64'd0);
        chk("rst2.dispatch_cnt", {60'd0, dispatch_cnt}, 64'd0);
        chk("rst2.iq_ready", {63'd0, bus.iq_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
